// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg -- shared definitions for the div32_seq sequential divider.
//   state_t   : controller state encoding (IDLE, RUN, FIX, DONE)
//   DIV_ITER  : number of restoring steps per division
//   LAST_CNT  : iteration-counter value during the final RUN step
//   DIVZ_QUOT : quotient returned for a zero divisor
//   cond_neg  : two's-complement negate when the select bit is set
// ---------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          DIV_ITER  = 32;
  localparam logic [5:0]  LAST_CNT  = 6'(DIV_ITER - 1);
  localparam logic [31:0] DIVZ_QUOT = 32'hFFFF_FFFF;

  // Negate a 32-bit value when neg is set; used for both magnitude
  // extraction at acceptance and sign restoration at the end.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    logic [31:0] res;
    if (neg) begin
      res = ~v + 32'd1;
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/div32_seq_sub33.sv
// ---------------------------------------------------------------------------
// sub33 -- combinational 33-bit subtractor used for the trial subtraction.
//   i_a      : minuend (shifted partial remainder)
//   i_b      : subtrahend (zero-extended divisor magnitude)
//   o_diff   : i_a - i_b modulo 2^33
//   o_borrow : 1 when i_a < i_b
// ---------------------------------------------------------------------------
module sub33 (
  input  logic [32:0] i_a,
  input  logic [32:0] i_b,
  output logic [32:0] o_diff,
  output logic        o_borrow
);

  logic [33:0] w_full;

  // One extra bit on the left catches the borrow out of the subtraction.
  assign w_full   = {1'b0, i_a} - {1'b0, i_b};
  assign o_diff   = w_full[32:0];
  assign o_borrow = w_full[33];

endmodule

// File: rtl/div32_seq.sv
// ---------------------------------------------------------------------------
// div32_seq -- 32-bit signed/unsigned restoring divider, one bit per cycle.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   start     : request a division (sampled only in IDLE)
//   sgn       : 1 = signed operands, 0 = unsigned (captured with start)
//   dividend  : numerator (captured with start)
//   divisor   : denominator (captured with start)
//   busy      : high while the divider is iterating or fixing signs
//   done      : one-cycle pulse, results valid
//   quotient  : result quotient, held until the next accepted start
//   remainder : result remainder, held until the next accepted start
//   div_zero  : divisor was zero
//   ovf       : signed overflow (-2^31 / -1)
// All outputs are registers; nothing passes combinationally from inputs.
// ---------------------------------------------------------------------------
module div32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             ovf
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_accept;
  logic        w_div_by_zero;

  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic [5:0]  r_cnt;
  logic        r_qneg;
  logic        r_rneg;
  logic        r_sgn;

  logic        r_busy;
  logic        r_done;
  logic [31:0] r_quotient;
  logic [31:0] r_remainder;
  logic        r_div_zero;
  logic        r_ovf;

  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_borrow;
  logic        w_unused_diff_msb;

  assign w_div_by_zero = (divisor == 32'd0);

  // Partial remainder shifted left with the next dividend bit brought in.
  assign w_shift = {r_rem, r_quo[31]};

  sub33 u_sub33 (
    .i_a      (w_shift),
    .i_b      ({1'b0, r_dvs}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  // A non-negative difference is always below the divisor, so bit 32 is
  // zero whenever it is kept.
  assign w_unused_diff_msb = w_diff[32];

  // Next-state logic and start acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (w_div_by_zero) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = RUN;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = FIX;
        end else begin
          w_state_nxt = RUN;
        end
      end
      FIX:     w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered status flags, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == RUN) || (w_state_nxt == FIX);
      r_done <= (w_state_nxt == DONE);
    end
  end

  // Operand capture, restoring iteration and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_quo       <= 32'd0;
      r_rem       <= 32'd0;
      r_dvs       <= 32'd0;
      r_cnt       <= 6'd0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_sgn       <= 1'b0;
      r_quotient  <= 32'd0;
      r_remainder <= 32'd0;
      r_div_zero  <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_quo  <= cond_neg(dividend, sgn & dividend[31]);
            r_dvs  <= cond_neg(divisor, sgn & divisor[31]);
            r_rem  <= 32'd0;
            r_cnt  <= 6'd0;
            r_qneg <= sgn & (dividend[31] ^ divisor[31]);
            r_rneg <= sgn & dividend[31];
            r_sgn  <= sgn;
            // A zero divisor skips the iteration and reports at once.
            if (w_div_by_zero) begin
              r_quotient  <= DIVZ_QUOT;
              r_remainder <= dividend;
              r_div_zero  <= 1'b1;
              r_ovf       <= 1'b0;
            end
          end
        end
        RUN: begin
          if (w_borrow) begin
            r_rem <= w_shift[31:0];
            r_quo <= {r_quo[30:0], 1'b0};
          end else begin
            r_rem <= w_diff[31:0];
            r_quo <= {r_quo[30:0], 1'b1};
          end
          r_cnt <= r_cnt + 6'd1;
        end
        FIX: begin
          r_quotient  <= cond_neg(r_quo, r_qneg);
          r_remainder <= cond_neg(r_rem, r_rneg);
          r_div_zero  <= 1'b0;
          // Only -2^31 / -1 yields a positive quotient magnitude of 2^31.
          r_ovf       <= r_sgn & ~r_qneg & r_quo[31];
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_div32_seq.sv
// ---------------------------------------------------------------------------
// tb_div32_seq -- self-checking bench for div32_seq.
// A reference model computes each result with plain integer arithmetic and
// tracks when done/busy must appear; a negedge process compares every cycle.
// Directed vectors additionally pin results and latencies to literal values.
// ---------------------------------------------------------------------------
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;
  logic        ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  div32_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sgn       (sgn),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic for one division.
  task automatic model_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r,
                           output bit dz, output bit ov);
    int sa;
    int sb;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q  = 32'h8000_0000;
      r  = 32'd0;
      ov = 1'b1;
    end else begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end
  endtask

  // Model state: countdown to done, expected flags, expected held results.
  bit          m_on = 1'b0;
  int          m_left = 0;
  bit          e_done = 1'b0;
  bit          e_busy = 1'b0;
  bit          e_hold = 1'b0;
  logic [31:0] e_q = 32'd0;
  logic [31:0] e_r = 32'd0;
  bit          e_dz = 1'b0;
  bit          e_ov = 1'b0;
  logic [31:0] p_q;
  logic [31:0] p_r;
  bit          p_dz;
  bit          p_ov;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_on   = 1'b1;
      m_left = 0;
      e_done = 1'b0;
      e_busy = 1'b0;
      e_hold = 1'b1;
      e_q    = 32'd0;
      e_r    = 32'd0;
      e_dz   = 1'b0;
      e_ov   = 1'b0;
    end else if (m_on) begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          e_busy = 1'b0;
          e_done = 1'b1;
          e_q    = p_q;
          e_r    = p_r;
          e_dz   = p_dz;
          e_ov   = p_ov;
          e_hold = 1'b1;
        end
      end else if (e_done) begin
        e_done = 1'b0;
      end else if (start) begin
        model_div(sgn, dividend, divisor, p_q, p_r, p_dz, p_ov);
        if (p_dz) begin
          e_done = 1'b1;
          e_q    = p_q;
          e_r    = p_r;
          e_dz   = p_dz;
          e_ov   = p_ov;
          e_hold = 1'b1;
        end else begin
          m_left = 33;
          e_busy = 1'b1;
          e_hold = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("busy", {31'd0, busy}, {31'd0, e_busy});
      check("done", {31'd0, done}, {31'd0, e_done});
      if (e_hold) begin
        check("quotient", quotient, e_q);
        check("remainder", remainder, e_r);
        check("div_zero", {31'd0, div_zero}, {31'd0, e_dz});
        check("ovf", {31'd0, ovf}, {31'd0, e_ov});
      end
    end
  end

  // Issue one division in the next IDLE cycle and check literal results.
  task automatic run_check(input string nm, input bit s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq,
                           input logic [31:0] er, input bit edz, input bit eov,
                           input int elat);
    int lat;
    @(negedge clk);
    sgn = s;
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      if (lat == 0) start = 1'b0;
      lat++;
      if (done) break;
    end
    check({nm, " latency"}, lat, elat);
    check({nm, " quotient"}, quotient, eq);
    check({nm, " remainder"}, remainder, er);
    check({nm, " div_zero"}, {31'd0, div_zero}, {31'd0, edz});
    check({nm, " ovf"}, {31'd0, ovf}, {31'd0, eov});
  endtask

  int lat;
  int c1;
  int c2;
  int n_done;

  initial begin
    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst quotient", quotient, 32'd0);
    check("rst remainder", remainder, 32'd0);
    check("rst flags", {30'd0, div_zero, ovf}, 32'd0);
    rst_n = 1'b1;

    // Basic directed vectors.
    run_check("u100/7",  1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34);
    run_check("s-7/2",   1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 34);
    run_check("u-7/2",   1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0, 34);
    run_check("divz",    1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 1);
    run_check("ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 34);
    run_check("s7/-2",   1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 34);
    run_check("s-7/-2",  1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 34);
    run_check("umax/max",1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 34);
    run_check("u0/5",    1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 34);
    run_check("smin/1",  1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 34);
    run_check("sdivz",   1'b1, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1);

    // Start pulsed mid-run must be ignored.
    @(negedge clk);
    sgn = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (lat == 10) begin
        sgn = 1'b1; dividend = 32'd5; divisor = 32'd5; start = 1'b1;
      end
      if (lat == 11) start = 1'b0;
      if (done) break;
    end
    check("ign latency", lat, 34);
    check("ign quotient", quotient, 32'd333);
    check("ign remainder", remainder, 32'd1);

    // Reset in the middle of a run, with start high in the reset cycle.
    @(negedge clk);
    sgn = 1'b0; dividend = 32'd50; divisor = 32'd6; start = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
    end
    rst_n = 1'b0; start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    check("mid-rst busy", {31'd0, busy}, 32'd0);
    check("mid-rst done", {31'd0, done}, 32'd0);
    check("mid-rst quotient", quotient, 32'd0);
    check("mid-rst remainder", remainder, 32'd0);
    check("mid-rst flags", {30'd0, div_zero, ovf}, 32'd0);
    rst_n = 1'b1; start = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("mid-rst no done", n_done, 0);

    // Back-to-back divisions with start held high.
    @(negedge clk);
    sgn = 1'b0; dividend = 32'hFFFF_FFFF; divisor = 32'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = 32'd1; divisor = 32'hFFFF_FFFF;
    c1 = -1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        c1 = cyc;
        break;
      end
      @(negedge clk);
    end
    check("b2b first quotient", quotient, 32'hFFFF_FFFF);
    check("b2b first remainder", remainder, 32'd0);
    c2 = -1000;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        c2 = cyc;
        break;
      end
    end
    start = 1'b0;
    check("b2b spacing", c2 - c1, 35);
    check("b2b second quotient", quotient, 32'd0);
    check("b2b second remainder", remainder, 32'd1);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div32_seq.md
DIV32_SEQ -- requirements
Module: div32_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port sgn  input  1  1 = signed two's-complement, 0 = unsigned; captured with start.
REQ-006 SHALL have port dividend  input  32  numerator; captured with start.
REQ-007 SHALL have port divisor  input  32  denominator; captured with start.
REQ-008 SHALL have port busy  output  1  high from the cycle after start acceptance until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-010 SHALL have port quotient  output  32  result quotient.
REQ-011 SHALL have port remainder  output  32  result remainder.
REQ-012 SHALL have port div_zero  output  1  divisor was zero; valid with done.
REQ-013 SHALL have port ovf  output  1  signed overflow (-2^31 / -1); valid with done.

Function
REQ-014 SHALL implement states IDLE, RUN, FIX, DONE; IDLE->RUN on start=1 with divisor!=0; IDLE->DONE on start=1 with divisor==0; RUN->FIX after 32 iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-015 SHALL, on acceptance, latch operand magnitudes (absolute values when sgn=1), the quotient sign (dividend[31]^divisor[31]) and the remainder sign (dividend[31]) when sgn=1; both signs 0 when sgn=0.
REQ-016 SHALL perform one restoring step per RUN cycle: shift {rem,quo} left 1, trial-subtract divisor magnitude from 33-bit partial remainder, keep difference and set quo LSB to 1 if non-negative, else restore and set LSB to 0.
REQ-017 SHALL use a 6-bit iteration counter, cleared on acceptance, terminating RUN after exactly 32 steps.
REQ-018 SHALL in FIX negate quotient if quotient sign set and negate remainder if remainder sign set.
REQ-019 SHALL assert done for exactly the DONE cycle, 34 cycles after the accepting edge for a nonzero divisor, and 1 cycle after it for a zero divisor.
REQ-020 SHALL hold quotient, remainder, div_zero and ovf stable from done until the next accepted start.
REQ-021 SHALL on divisor==0 return quotient=32'hFFFFFFFF, remainder=dividend (unmodified), div_zero=1, ovf=0.
REQ-022 SHALL on sgn=1, dividend=32'h80000000, divisor=32'hFFFFFFFF return quotient=32'h80000000, remainder=0, ovf=1 (natural result of the algorithm, no special-case path required).
REQ-023 SHALL ignore start while busy or in DONE; no operand is captured.
REQ-024 SHALL accept start in the IDLE cycle immediately following DONE (back-to-back throughput: one division per 35 cycles).
REQ-025 SHALL derive div_zero and ovf only at acceptance/FIX; both 0 in every other result.

Reset
REQ-026 SHALL on rst_n=0 at a clock edge enter IDLE and clear busy, done, quotient, remainder, div_zero, ovf, counter and all datapath registers to 0.
REQ-027 SHALL abort any in-progress division on reset with no done pulse; start sampled in the reset cycle is ignored.

Structure
REQ-028 SHALL place state encoding, DIV_ITER=32, and DIVZ_QUOT=32'hFFFFFFFF in shared package div_pkg.
REQ-029 SHALL instantiate one sub-module, sub33, a combinational 33-bit subtractor returning difference and borrow, used for the trial subtraction.
REQ-030 SHALL contain no combinational path from inputs to outputs.

Verification
REQ-031 SHALL test: sgn=0, 100/7 -> done 34 cycles after start, quotient=14, remainder=2, flags 0.
REQ-032 SHALL test: sgn=1, -7/2 (32'hFFFFFFF9 / 2) -> quotient=32'hFFFFFFFD, remainder=32'hFFFFFFFF; sgn=0 same bits -> quotient=32'h7FFFFFFC, remainder=1.
REQ-033 SHALL test: divisor=0, dividend=32'h12345678 -> done next cycle, quotient=32'hFFFFFFFF, remainder=32'h12345678, div_zero=1.
REQ-034 SHALL test: sgn=1, 32'h80000000 / 32'hFFFFFFFF -> quotient=32'h80000000, remainder=0, ovf=1.
REQ-035 SHALL test: start pulsed at cycle 10 of a run with different operands -> ignored; first result unchanged; rst_n=0 at cycle 20 of a run -> IDLE next cycle, all outputs 0, no done.
REQ-036 SHALL test: back-to-back starts (start held high) -> done pulses exactly 35 cycles apart with correct results for 0xFFFFFFFF/1 and 1/0xFFFFFFFF unsigned (quotient 0xFFFFFFFF/remainder 0; quotient 0/remainder 1).
